// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-SRAM responder and its storage array.
package dsram_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  localparam logic [LANES-1:0] WEN_READ = 4'b0000;

endpackage

// File: rtl/dsram_array.sv
// Word-organised data memory with per-byte-lane writes and a registered read word.
module dsram_array
  import dsram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [LANES-1:0]  i_wen,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  logic [WORD_W-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto SRAM macros; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (i_wen[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Only a completing read reloads the word; writes leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_rdata <= '0;
    else if (i_en && i_wen == WEN_READ) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_responder.sv
// Responder for the EX-stage data-SRAM interface: optional wait states with a stall
// request, a held copy of the stalled request, and the backing array.
module data_sram_responder
  import dsram_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [LANES-1:0]  data_sram_wen,
  input  logic [31:0]       data_sram_addr,
  input  logic [WORD_W-1:0] data_sram_wdata,
  output logic [WORD_W-1:0] data_sram_rdata,
  output logic              stallreq_mem
);

  localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_cnt;
  logic [ADDR_W-1:0]  r_req_idx;
  logic [LANES-1:0]   r_req_wen;
  logic [WORD_W-1:0]  r_req_wdata;

  logic [ADDR_W-1:0]  w_in_idx;
  logic               w_start;
  logic               w_acc_en;
  logic [LANES-1:0]   w_acc_wen;
  logic [ADDR_W-1:0]  w_acc_idx;
  logic [WORD_W-1:0]  w_acc_wdata;
  logic               w_unused_addr;

  // High address bits alias and the byte offset is the requester's business.
  assign w_in_idx      = data_sram_addr[ADDR_W+1:2];
  assign w_unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
  assign w_start       = (r_state == IDLE) && data_sram_en && HAS_WAIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_idx   <= '0;
      r_req_wen   <= WEN_READ;
      r_req_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_cnt       <= CNT_INIT;
        r_req_idx   <= w_in_idx;
        r_req_wen   <= data_sram_wen;
        r_req_wdata <= data_sram_wdata;
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (data_sram_en && HAS_WAIT) w_next_state = BUSY;
      BUSY:    if (r_cnt == 4'd0)            w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    stallreq_mem = 1'b0;
    w_acc_en     = 1'b0;
    w_acc_wen    = data_sram_wen;
    w_acc_idx    = w_in_idx;
    w_acc_wdata  = data_sram_wdata;
    case (r_state)
      IDLE: begin
        stallreq_mem = data_sram_en && HAS_WAIT;
        w_acc_en     = data_sram_en && !HAS_WAIT;
      end
      BUSY: begin
        // The completion cycle replays the held request; live inputs are ignored.
        stallreq_mem = (r_cnt != 4'd0);
        w_acc_en     = (r_cnt == 4'd0);
        w_acc_wen    = r_req_wen;
        w_acc_idx    = r_req_idx;
        w_acc_wdata  = r_req_wdata;
      end
      default: ;
    endcase
    if (rst) begin
      stallreq_mem = 1'b0;
      w_acc_en     = 1'b0;
    end
  end

  dsram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_acc_en),
    .i_wen   (w_acc_wen),
    .i_idx   (w_acc_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (data_sram_rdata)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: four responders with different wait-state counts, driven one at a
// time, with read results checked against a scoreboard queue.
module tb_data_sram_responder;
  import dsram_pkg::*;

  localparam int NI = 4;

  function automatic int wait_of(input int k);
    case (k)
      0:       return 0;
      1:       return 3;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst   [NI];
  logic        en    [NI];
  logic [3:0]  wen   [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic        stall [NI];

  int          n_checks = 0;
  int          n_errors = 0;
  int          stalls;
  logic [31:0] sb_q [$];
  logic [31:0] model [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    data_sram_responder #(
      .ADDR_W      (10),
      .WAIT_CYCLES (wait_of(g))
    ) u_dut (
      .clk             (clk),
      .rst             (rst[g]),
      .data_sram_en    (en[g]),
      .data_sram_wen   (wen[g]),
      .data_sram_addr  (addr[g]),
      .data_sram_wdata (wdata[g]),
      .data_sram_rdata (rdata[g]),
      .stallreq_mem    (stall[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request (held while stalled), count stall cycles, then check the result
  // in the cycle after completion. Returns just after the following falling edge.
  task automatic access(input int k, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
    logic [31:0] prev;
    int          n;
    prev     = rdata[k];
    en[k]    = 1'b1;
    wen[k]   = w;
    addr[k]  = a;
    wdata[k] = d;
    if (w == 4'b0000) sb_q.push_back(exp_rd);
    #1;
    n = 0;
    while (stall[k] && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    check($sformatf("stall_len_i%0d_a%08h", k, a), 32'(n), 32'(wait_of(k)));
    @(negedge clk); #1;
    if (w == 4'b0000) begin
      if (sb_q.size() > 0) check($sformatf("rdata_i%0d_a%08h", k, a), rdata[k], sb_q.pop_front());
    end else begin
      check($sformatf("rdata_hold_i%0d_a%08h", k, a), rdata[k], prev);
    end
  endtask

  // One cycle with en low; a stall here would mean a spurious access was started.
  task automatic idle(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en[k]    = 1'b0;
    wen[k]   = w;
    addr[k]  = a;
    wdata[k] = d;
    #1;
    check($sformatf("idle_stall_i%0d", k), 32'(stall[k]), 32'd0);
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; en[k] = 1'b0; wen[k] = 4'h0; addr[k] = '0; wdata[k] = '0;
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_rdata_i%0d", k), rdata[k], 32'd0);
      check($sformatf("reset_stall_i%0d", k), 32'(stall[k]), 32'd0);
    end
    @(negedge clk); @(negedge clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    #1;

    // N=0: word write then back-to-back read of the same word.
    access(0, 4'hF, 32'h40, 32'hDEADBEEF, 0);
    access(0, 4'h0, 32'h40, 0, 32'hDEADBEEF);
    idle(0, 4'h0, 0, 0);

    // N=0: byte and halfword lane merges.
    access(0, 4'hF, 32'h80, 32'h11223344, 0);
    access(0, 4'b0010, 32'h80, 32'h0000AA00, 0);
    access(0, 4'b1100, 32'h80, 32'h55660000, 0);
    access(0, 4'h0, 32'h80, 0, 32'h5566AA44);
    idle(0, 4'h0, 0, 0);

    // Aliasing: bit 12 lies above the word index, so 0x1004 lands on word 1.
    access(0, 4'hF, 32'h00001004, 32'hA5A55A5A, 0);
    access(0, 4'h0, 32'h00000004, 0, 32'hA5A55A5A);
    idle(0, 4'hF, 32'h4, 32'hFFFFFFFF);
    access(0, 4'h0, 32'h00000004, 0, 32'hA5A55A5A);
    idle(0, 4'h0, 0, 0);

    // N=3: stalled read, held request in the completion cycle must not restart.
    access(1, 4'hF, 32'h100, 32'h0BADF00D, 0);
    idle(1, 4'h0, 0, 0);
    access(1, 4'h0, 32'h100, 0, 32'h0BADF00D);
    idle(1, 4'h0, 0, 0);

    // N=2: memory must stay untouched while the write is stalled.
    access(2, 4'hF, 32'h20, 32'h00000000, 0);
    idle(2, 4'h0, 0, 0);
    en[2] = 1'b1; wen[2] = 4'hF; addr[2] = 32'h20; wdata[2] = 32'hCAFEF00D;
    #1;
    stalls = 0;
    while (stall[2] && stalls < 20) begin
      check("wr_stall_mem_hold", gen_dut[2].u_dut.u_array.r_mem[8], 32'd0);
      stalls++;
      @(negedge clk); #1;
    end
    check("wr_stall_len", 32'(stalls), 32'd2);
    @(negedge clk); #1;
    idle(2, 4'h0, 0, 0);
    access(2, 4'h0, 32'h20, 0, 32'hCAFEF00D);
    idle(2, 4'h0, 0, 0);

    // N=4: reset two cycles into a write drops it.
    access(3, 4'hF, 32'h30, 32'h00000000, 0);
    access(3, 4'hF, 32'h34, 32'hFFFF0000, 0);
    access(3, 4'h0, 32'h34, 0, 32'hFFFF0000);
    en[3] = 1'b1; wen[3] = 4'hF; addr[3] = 32'h30; wdata[3] = 32'h12345678;
    @(negedge clk); @(negedge clk);
    rst[3] = 1'b1;
    #1;
    check("rst_mid_busy_stall", 32'(stall[3]), 32'd0);
    check("rst_mid_busy_rdata", rdata[3], 32'd0);
    check("rst_mid_busy_state", 32'(gen_dut[3].u_dut.r_state), 32'(IDLE));
    @(negedge clk);
    rst[3] = 1'b0; en[3] = 1'b0; wen[3] = 4'h0;
    #1;
    access(3, 4'h0, 32'h30, 0, 32'h00000000);
    idle(3, 4'h0, 0, 0);

    // N=0: random lane writes and aliased reads against a small word model.
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      access(0, 4'hF, 32'(i * 4), model[i], 0);
    end
    for (int j = 0; j < 24; j++) begin
      int          ix;
      logic [3:0]  w;
      logic [31:0] d;
      logic [31:0] a;
      ix = $urandom_range(0, 7);
      w  = (j % 2 == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      d  = $urandom;
      a  = 32'(ix * 4) | ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 3));
      if (w != 4'h0) begin
        for (int l = 0; l < 4; l++) if (w[l]) model[ix][8*l +: 8] = d[8*l +: 8];
      end
      access(0, w, a, d, model[ix]);
    end
    idle(0, 4'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
